strip_placement_scheduler: RTL and testbench

// - Sequences program placement on the 128x128 grid of 13 fixed-height strips.
// - Accepts one request (width, height) and scans all strips, one per cycle.
// - Picks the best-fit strip, owns the per-strip occupied-width registers and

---
 rtl/strip_placement_scheduler.sv | 158 +++++++++++++++
 tb/tb_strip_placement_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/strip_placement_scheduler.sv
// Best-fit strip placement over 13 fixed-height strips: scans one strip per cycle,
// reports the chosen strip and its x start, and commits occupancy when the result is consumed.
module strip_placement_scheduler #(
  parameter int GRID_W   = 128,
  parameter int W_BITS   = 8,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [W_BITS-1:0]   req_width_in,
  input  logic [4:0]          req_height_in,
  output logic                res_valid_out,
  input  logic                res_ready_in,
  output logic [3:0]          strip_ID_out,
  output logic [W_BITS-1:0]   occupied_width_out,
  output logic                strike_flag_out,
  output logic [CNT_BITS-1:0] strike_cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  localparam logic [W_BITS:0] GRID_LIM = (W_BITS+1)'(GRID_W);
  localparam logic [3:0]      LAST_ID  = 4'd13;

  // Slot 0 and 14..15 are never written; they keep index 0 (no strip) safe to read.
  state_t              r_state;
  logic [W_BITS-1:0]   r_occ [0:15];
  logic [W_BITS-1:0]   r_w;
  logic [4:0]          r_h;
  logic                r_illegal;
  logic [3:0]          r_idx;
  logic [3:0]          r_best;

  logic [4:0]          w_h_idx;
  logic [W_BITS:0]     w_sum;
  logic                w_fit;
  logic [3:0]          w_next_best;

  function automatic logic [4:0] strip_height(input logic [3:0] id);
    case (id)
      4'd1:    return 5'd8;
      4'd2:    return 5'd8;
      4'd3:    return 5'd9;
      4'd4:    return 5'd7;
      4'd5:    return 5'd10;
      4'd6:    return 5'd6;
      4'd7:    return 5'd11;
      4'd8:    return 5'd5;
      4'd9:    return 5'd12;
      4'd10:   return 5'd4;
      4'd11:   return 5'd16;
      4'd12:   return 5'd16;
      4'd13:   return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  // Fit test for the strip under scan; strict height compare keeps the lowest ID on ties.
  always_comb begin
    w_h_idx     = strip_height(r_idx);
    w_sum       = {1'b0, r_occ[r_idx]} + {1'b0, r_w};
    w_fit       = (w_h_idx >= r_h) && (w_sum <= GRID_LIM);
    w_next_best = r_best;
    if (w_fit && ((r_best == 4'd0) || (w_h_idx < strip_height(r_best)))) begin
      w_next_best = r_idx;
    end else begin
      w_next_best = r_best;
    end
  end

  // Control FSM, occupancy table, strike counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_in) begin
      r_state            <= S_IDLE;
      for (int i = 0; i < 16; i++) r_occ[i] <= '0;
      r_w                <= '0;
      r_h                <= 5'd0;
      r_illegal          <= 1'b0;
      r_idx              <= 4'd1;
      r_best             <= 4'd0;
      req_ready_out      <= 1'b1;
      res_valid_out      <= 1'b0;
      strip_ID_out       <= 4'd0;
      occupied_width_out <= '0;
      strike_flag_out    <= 1'b0;
      strike_cnt_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          req_ready_out <= 1'b1;
          if (req_valid_in) begin
            r_w           <= req_width_in;
            r_h           <= req_height_in;
            r_illegal     <= (req_width_in == '0) || ({1'b0, req_width_in} > GRID_LIM) ||
                             (req_height_in == 5'd0) || (req_height_in > 5'd16);
            r_idx         <= 4'd1;
            r_best        <= 4'd0;
            req_ready_out <= 1'b0;
            r_state       <= S_SCAN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SCAN: begin
          r_best <= w_next_best;
          r_idx  <= r_idx + 4'd1;
          if (r_idx == LAST_ID) begin
            r_state       <= S_RESULT;
            res_valid_out <= 1'b1;
            if (r_illegal || (w_next_best == 4'd0)) begin
              r_best             <= 4'd0;
              strip_ID_out       <= 4'd0;
              occupied_width_out <= '0;
              strike_flag_out    <= 1'b1;
            end else begin
              strip_ID_out       <= w_next_best;
              occupied_width_out <= r_occ[w_next_best];
              strike_flag_out    <= 1'b0;
            end
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_RESULT: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            req_ready_out <= 1'b1;
            r_state       <= S_IDLE;
            if (strike_flag_out) begin
              if (strike_cnt_out != {CNT_BITS{1'b1}}) begin
                strike_cnt_out <= strike_cnt_out + {{(CNT_BITS-1){1'b0}}, 1'b1};
              end else begin
                strike_cnt_out <= strike_cnt_out;
              end
            end else begin
              r_occ[r_best] <= r_occ[r_best] + r_w;
            end
          end else begin
            r_state <= S_RESULT;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          req_ready_out <= 1'b1;
          res_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strip_placement_scheduler.sv
// Directed bench for strip_placement_scheduler: expected results are queued when a
// request is driven and checked when the matching result appears.
module tb_strip_placement_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_in = 1'b0;
  logic       req_valid_in = 1'b0;
  logic       req_ready_out;
  logic [7:0] req_width_in = 8'd0;
  logic [4:0] req_height_in = 5'd0;
  logic       res_valid_out;
  logic       res_ready_in = 1'b0;
  logic [3:0] strip_ID_out;
  logic [7:0] occupied_width_out;
  logic       strike_flag_out;
  logic [7:0] strike_cnt_out;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] x;
    logic       strike;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  strip_placement_scheduler dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clear_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_width_in(req_width_in), .req_height_in(req_height_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .strip_ID_out(strip_ID_out), .occupied_width_out(occupied_width_out),
    .strike_flag_out(strike_flag_out), .strike_cnt_out(strike_cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] w, input logic [4:0] h);
    chk("req_ready_idle", 32'(req_ready_out), 32'd1);
    req_valid_in  = 1'b1;
    req_width_in  = w;
    req_height_in = h;
    tick();
    req_valid_in  = 1'b0;
  endtask

  task automatic expect_res(input logic [3:0] id, input logic [7:0] x, input logic strike);
    exp_t e;
    e.id = id; e.x = x; e.strike = strike;
    sb.push_back(e);
  endtask

  // Wait for the result, compare against the scoreboard head, then consume it.
  task automatic get_result(input string tag);
    int   n = 0;
    exp_t e;
    while (!res_valid_out && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd13);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(strip_ID_out), 32'(e.id));
      chk({tag, "_x"}, 32'(occupied_width_out), 32'(e.x));
      chk({tag, "_strike"}, 32'(strike_flag_out), 32'(e.strike));
    end
    chk({tag, "_ready_busy"}, 32'(req_ready_out), 32'd0);
    res_ready_in = 1'b1;
    tick();
    res_ready_in = 1'b0;
    chk({tag, "_valid_drop"}, 32'(res_valid_out), 32'd0);
    tick();
  endtask

  task automatic place(input string tag, input logic [7:0] w, input logic [4:0] h,
                       input logic [3:0] id, input logic [7:0] x, input logic strike);
    expect_res(id, x, strike);
    send_req(w, h);
    get_result(tag);
  endtask

  initial begin
    int bad;
    exp_t held;
    tick(); tick();
    chk("rst_ready", 32'(req_ready_out), 32'd1);
    chk("rst_valid", 32'(res_valid_out), 32'd0);
    chk("rst_id", 32'(strip_ID_out), 32'd0);
    chk("rst_x", 32'(occupied_width_out), 32'd0);
    chk("rst_strike", 32'(strike_flag_out), 32'd0);
    chk("rst_cnt", 32'(strike_cnt_out), 32'd0);
    rst_n = 1'b1;
    tick();

    place("first", 8'd10, 5'd5, 4'd8, 8'd0, 1'b0);
    place("tall1", 8'd100, 5'd16, 4'd11, 8'd0, 1'b0);
    place("tall2", 8'd100, 5'd16, 4'd12, 8'd0, 1'b0);
    place("tall3", 8'd100, 5'd16, 4'd13, 8'd0, 1'b0);
    place("tall4", 8'd100, 5'd16, 4'd0, 8'd0, 1'b1);
    chk("cnt_after_tall", 32'(strike_cnt_out), 32'd1);

    place("tie", 8'd120, 5'd8, 4'd1, 8'd0, 1'b0);
    place("fill", 8'd8, 5'd8, 4'd1, 8'd120, 1'b0);
    place("full", 8'd1, 5'd8, 4'd2, 8'd0, 1'b0);

    place("ill_w0", 8'd0, 5'd4, 4'd0, 8'd0, 1'b1);
    place("ill_w129", 8'd129, 5'd4, 4'd0, 8'd0, 1'b1);
    place("ill_h17", 8'd8, 5'd17, 4'd0, 8'd0, 1'b1);
    chk("cnt_after_illegal", 32'(strike_cnt_out), 32'd4);
    place("occ_kept", 8'd1, 5'd8, 4'd2, 8'd1, 1'b0);

    // Backpressure: result must stay put for 20 cycles, then commit exactly once.
    expect_res(4'd2, 8'd2, 1'b0);
    send_req(8'd5, 5'd8);
    for (int i = 0; i < 13; i++) tick();
    held = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!res_valid_out || strip_ID_out !== held.id || occupied_width_out !== held.x ||
          strike_flag_out !== held.strike || req_ready_out !== 1'b0) bad++;
      tick();
    end
    chk("bp_stable_cycles", 32'(bad), 32'd0);
    chk("bp_id", 32'(strip_ID_out), 32'(held.id));
    chk("bp_x", 32'(occupied_width_out), 32'(held.x));
    res_ready_in = 1'b1;
    tick(); tick(); tick();
    res_ready_in = 1'b0;
    chk("bp_released", 32'(res_valid_out), 32'd0);
    place("bp_single_commit", 8'd1, 5'd8, 4'd2, 8'd7, 1'b0);

    // Flush mid-scan: the pending result is dropped and occupancy cleared.
    send_req(8'd50, 5'd8);
    tick(); tick(); tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid_out !== 1'b0) bad++;
      tick();
    end
    chk("flush_no_valid", 32'(bad), 32'd0);
    chk("flush_cnt", 32'(strike_cnt_out), 32'd0);
    place("after_flush", 8'd5, 5'd4, 4'd10, 8'd0, 1'b0);
    place("flush_occ1", 8'd120, 5'd8, 4'd1, 8'd0, 1'b0);

    // Reset mid-scan returns to reset values without committing.
    send_req(8'd10, 5'd8);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_ready", 32'(req_ready_out), 32'd1);
    chk("mrst_valid", 32'(res_valid_out), 32'd0);
    chk("mrst_id", 32'(strip_ID_out), 32'd0);
    rst_n = 1'b1;
    tick();
    place("after_mrst", 8'd128, 5'd8, 4'd1, 8'd0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
